// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one off-chip memory port between the I-cache
// refill path and the D-cache refill/write-back path; all outputs registered.
module mem_port_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [1:0]        owner
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_I    = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                op_write_q, op_write_d;
  logic [DATA_W-1:0]   resp_q, resp_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic                i_ready_q, i_ready_d;
  logic                d_ready_q, d_ready_d;
  logic [1:0]          owner_q, owner_d;

  logic d_req;
  logic grant_d_side;
  logic grant_i_side;

  // D wins on contention unless it was the last side served.
  always_comb begin
    d_req        = d_read | d_write;
    grant_d_side = d_req && (!i_read || (last_grant_q == GRANT_I));
    grant_i_side = i_read && !grant_d_side;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    op_write_d   = op_write_q;
    resp_d       = resp_q;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    i_ready_d    = 1'b0;
    d_ready_d    = 1'b0;
    owner_d      = owner_q;

    unique case (state_q)
      IDLE: begin
        owner_d = OWN_NONE;
        if (grant_d_side) begin
          state_d      = SERVE_D;
          last_grant_d = GRANT_D;
          addr_d       = d_addr;
          op_write_d   = d_write;
          if (d_write) begin
            wdata_d = d_wdata;
          end
          mem_read_d  = !d_write;
          mem_write_d = d_write;
          owner_d     = OWN_D;
        end else if (grant_i_side) begin
          state_d      = SERVE_I;
          last_grant_d = GRANT_I;
          addr_d       = i_addr;
          op_write_d   = 1'b0;
          mem_read_d   = 1'b1;
          owner_d      = OWN_I;
        end
      end

      SERVE_I, SERVE_D: begin
        if (mem_ready) begin
          state_d   = RESP;
          resp_d    = mem_rdata;
          i_ready_d = (state_q == SERVE_I);
          d_ready_d = (state_q == SERVE_D);
        end else begin
          mem_read_d  = !op_write_q;
          mem_write_d = op_write_q;
        end
      end

      RESP: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end

      default: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  // Reset abandons any transaction in flight, including its strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_I;
      addr_q       <= '0;
      wdata_q      <= '0;
      op_write_q   <= 1'b0;
      resp_q       <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      i_ready_q    <= 1'b0;
      d_ready_q    <= 1'b0;
      owner_q      <= OWN_NONE;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      op_write_q   <= op_write_d;
      resp_q       <= resp_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      i_ready_q    <= i_ready_d;
      d_ready_q    <= d_ready_d;
      owner_q      <= owner_d;
    end
  end

  always_comb begin
    i_rdata   = resp_q;
    d_rdata   = resp_q;
    i_ready   = i_ready_q;
    d_ready   = d_ready_q;
    mem_read  = mem_read_q;
    mem_write = mem_write_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    owner     = owner_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter: lone requests, contention,
// mid-transaction reset, dropped requests and zero-wait alternation.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;

  logic              clk;
  logic              rst_n;
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ready;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic [1:0]        owner;

  int totalChecks = 0;
  int passCount   = 0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_read    (i_read),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_ready   (i_ready),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ready   (d_ready),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .owner     (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    totalChecks++;
    if (obs === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, ".mem_read"},  mem_read,  1'b0);
    checkOutput({tag, ".mem_write"}, mem_write, 1'b0);
    checkOutput({tag, ".i_ready"},   i_ready,   1'b0);
    checkOutput({tag, ".d_ready"},   d_ready,   1'b0);
    checkOutput({tag, ".owner"},     owner,     2'd0);
    checkOutput({tag, ".mem_addr"},  mem_addr,  '0);
    checkOutput({tag, ".mem_wdata"}, mem_wdata, '0);
    checkOutput({tag, ".i_rdata"},   i_rdata,   '0);
    checkOutput({tag, ".d_rdata"},   d_rdata,   '0);
  endtask

  // Caller is in the IDLE cycle where the request is already driven (cycle 0).
  // Returns in cycle k+2 (IDLE again).
  task automatic applyStimulus(input string tag, input bit isD, input bit isWrite,
                               input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                               input int k, input logic [DATA_W-1:0] rdata, input bit dropEarly);
    logic [1:0] expOwner;
    expOwner = isD ? 2'd2 : 2'd1;
    for (int c = 1; c <= k; c++) begin
      tick();
      if (c == 1 && dropEarly) begin
        d_read  = 1'b0;
        d_write = 1'b0;
        i_read  = 1'b0;
      end
      checkOutput({tag, ".mem_read"},  mem_read,  !isWrite);
      checkOutput({tag, ".mem_write"}, mem_write, isWrite);
      checkOutput({tag, ".mem_addr"},  mem_addr,  addr);
      checkOutput({tag, ".owner"},     owner,     expOwner);
      checkOutput({tag, ".ready_early"}, {i_ready, d_ready}, 2'b00);
      if (isWrite) checkOutput({tag, ".mem_wdata"}, mem_wdata, wdata);
      if (c == k) begin
        mem_ready = 1'b1;
        mem_rdata = rdata;
      end
    end
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    checkOutput({tag, ".resp_strobes"}, {mem_read, mem_write}, 2'b00);
    checkOutput({tag, ".i_ready"}, i_ready, !isD);
    checkOutput({tag, ".d_ready"}, d_ready, isD);
    checkOutput({tag, ".resp_owner"}, owner, expOwner);
    if (!isWrite) begin
      if (isD) checkOutput({tag, ".d_rdata"}, d_rdata, rdata);
      else     checkOutput({tag, ".i_rdata"}, i_rdata, rdata);
    end
    if (isD) begin
      d_read  = 1'b0;
      d_write = 1'b0;
    end else begin
      i_read = 1'b0;
    end
    tick();
    checkOutput({tag, ".after_ready"}, {i_ready, d_ready}, 2'b00);
    checkOutput({tag, ".idle_owner"}, owner, 2'd0);
  endtask

  initial begin
    logic [DATA_W-1:0] ones;
    logic [DATA_W-1:0] beef;
    logic [1:0]        expOwner;
    int                phase;
    int                slot;
    ones = {4{32'h11111111}};
    beef = {4{32'hDEADBEEF}};

    rst_n = 1'b1; i_read = 1'b0; i_addr = '0; d_read = 1'b0; d_write = 1'b0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;

    applyReset();
    checkResetOutputs("reset");

    $display("[TB] lone I read");
    i_read = 1'b1; i_addr = 28'h0000010;
    applyStimulus("iRead", 1'b0, 1'b0, 28'h0000010, '0, 3, ones, 1'b0);

    $display("[TB] lone D write");
    d_write = 1'b1; d_addr = 28'h00000A0; d_wdata = beef;
    applyStimulus("dWrite", 1'b1, 1'b1, 28'h00000A0, beef, 2, {4{32'h22222222}}, 1'b0);

    $display("[TB] contention after reset");
    applyReset();
    checkResetOutputs("reset2");
    i_read = 1'b1; i_addr = 28'h0000100;
    d_read = 1'b1; d_addr = 28'h0000200;
    applyStimulus("contD", 1'b1, 1'b0, 28'h0000200, '0, 2, {4{32'h33333333}}, 1'b0);
    applyStimulus("contI", 1'b0, 1'b0, 28'h0000100, '0, 2, {4{32'h44444444}}, 1'b0);

    $display("[TB] reset during SERVE_D");
    d_write = 1'b1; d_addr = 28'h0000055; d_wdata = {4{32'hCAFEF00D}};
    tick();
    checkOutput("rstMid.mem_write", mem_write, 1'b1);
    checkOutput("rstMid.owner", owner, 2'd2);
    tick();
    rst_n = 1'b0;
    tick();
    checkResetOutputs("rstMid");
    rst_n = 1'b1;
    d_write = 1'b0;
    tick();
    checkOutput("rstMid.idle_owner", owner, 2'd0);
    mem_ready = 1'b1;
    mem_rdata = {4{32'h99999999}};
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    checkOutput("lateReady.strobes", {mem_read, mem_write}, 2'b00);
    checkOutput("lateReady.ready", {i_ready, d_ready}, 2'b00);
    checkOutput("lateReady.rdata", i_rdata, '0);
    i_read = 1'b1; i_addr = 28'h0000020;
    applyStimulus("postRst", 1'b0, 1'b0, 28'h0000020, '0, 1, {4{32'h55555555}}, 1'b0);

    $display("[TB] D request dropped mid-transaction");
    d_read = 1'b1; d_addr = 28'h0000077;
    applyStimulus("dDrop", 1'b1, 1'b0, 28'h0000077, '0, 5, {4{32'h66666666}}, 1'b1);

    $display("[TB] illegal read+write treated as write");
    d_read = 1'b1; d_write = 1'b1; d_addr = 28'h0000099; d_wdata = {4{32'h0BADC0DE}};
    applyStimulus("dBoth", 1'b1, 1'b1, 28'h0000099, {4{32'h0BADC0DE}}, 1, {4{32'h77777777}}, 1'b0);

    $display("[TB] zero-wait memory, both requesters continuous");
    applyReset();
    mem_ready = 1'b1;
    mem_rdata = {4{32'hA5A5A5A5}};
    i_read = 1'b1; i_addr = 28'h0000300;
    d_read = 1'b1; d_addr = 28'h0000400;
    for (int c = 1; c <= 12; c++) begin
      tick();
      phase = c % 3;
      slot = (c - 1) / 3;
      expOwner = (slot % 2 == 0) ? 2'd2 : 2'd1;
      checkOutput("zw.no_overlap", mem_read & mem_write, 1'b0);
      if (phase == 1) begin
        checkOutput("zw.serve_read", mem_read, 1'b1);
        checkOutput("zw.serve_owner", owner, expOwner);
        checkOutput("zw.serve_addr", mem_addr, (expOwner == 2'd2) ? 28'h0000400 : 28'h0000300);
      end else if (phase == 2) begin
        checkOutput("zw.resp_read", mem_read, 1'b0);
        checkOutput("zw.resp_owner", owner, expOwner);
        checkOutput("zw.resp_ready", {i_ready, d_ready}, (expOwner == 2'd2) ? 2'b01 : 2'b10);
      end else begin
        checkOutput("zw.idle_owner", owner, 2'd0);
        checkOutput("zw.idle_ready", {i_ready, d_ready}, 2'b00);
      end
    end
    i_read = 1'b0;
    d_read = 1'b0;
    mem_ready = 1'b0;

    $display("%0d/%0d checks passed", passCount, totalChecks);
    $finish;
  end

endmodule
